// File: rtl/ctrl_pipe_unit.sv
// ctrl_pipe_unit: ID-stage control decode, load-use stall and the ID/EX control register.
// Define CTRL_PIPE_MD_UNIT_EN to enable the MULT/DIV busy sequencer (otherwise MULT/DIV are illegal).
module ctrl_pipe_unit #(
  parameter int ALUC_W    = 4,
  parameter int MD_CYCLES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instr,
  input  logic              id_valid,
  input  logic              ex_ready,
  input  logic              flush,
  output logic              id_ready,
  output logic              ex_valid,
  output logic [1:0]        ex_wb,
  output logic [1:0]        ex_m,
  output logic [ALUC_W+1:0] ex_ex,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic              beq,
  output logic              bne,
  output logic              jump,
  output logic              md_busy,
  output logic              illegal
);

  localparam logic [ALUC_W-1:0] ALU_AND = ALUC_W'(4'b0000);
  localparam logic [ALUC_W-1:0] ALU_OR  = ALUC_W'(4'b0001);
  localparam logic [ALUC_W-1:0] ALU_ADD = ALUC_W'(4'b0010);
  localparam logic [ALUC_W-1:0] ALU_SRL = ALUC_W'(4'b0011);
  localparam logic [ALUC_W-1:0] ALU_SUB = ALUC_W'(4'b0110);
  localparam logic [ALUC_W-1:0] ALU_SLT = ALUC_W'(4'b0111);
  localparam logic [ALUC_W-1:0] ALU_XOR = ALUC_W'(4'b1001);
  localparam logic [ALUC_W-1:0] ALU_SLL = ALUC_W'(4'b1010);
  localparam logic [ALUC_W-1:0] ALU_SRA = ALUC_W'(4'b1011);
  localparam logic [ALUC_W-1:0] ALU_NOR = ALUC_W'(4'b1100);
`ifdef CTRL_PIPE_MD_UNIT_EN
  localparam logic [ALUC_W-1:0] ALU_MUL = ALUC_W'(4'b0100);
  localparam logic [ALUC_W-1:0] ALU_DIV = ALUC_W'(4'b0101);
`endif

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  logic [5:0]        op_p0;
  logic [5:0]        fn_p0;
  logic [4:0]        rs_p0;
  logic [4:0]        rt_p0;
  logic [4:0]        rd_p0;
  logic              regwr_p0;
  logic              memtoreg_p0;
  logic              memrd_p0;
  logic              memwr_p0;
  logic              regdst_p0;
  logic              alusrc_p0;
  logic [ALUC_W-1:0] aluc_p0;
  logic              beq_p0;
  logic              bne_p0;
  logic              jump_p0;
  logic              known_p0;
  logic              rtsrc_p0;
`ifdef CTRL_PIPE_MD_UNIT_EN
  logic              md_p0;
`endif
  logic              unused_shamt;

  assign op_p0        = instr[31:26];
  assign rs_p0        = instr[25:21];
  assign rt_p0        = instr[20:16];
  assign rd_p0        = instr[15:11];
  assign fn_p0        = instr[5:0];
  assign unused_shamt = ^instr[10:6];

  // ---- ID stage (p0): combinational decode ----
  always_comb begin
    regwr_p0    = 1'b0;
    memtoreg_p0 = 1'b0;
    memrd_p0    = 1'b0;
    memwr_p0    = 1'b0;
    regdst_p0   = 1'b0;
    alusrc_p0   = 1'b0;
    aluc_p0     = ALU_AND;
    beq_p0      = 1'b0;
    bne_p0      = 1'b0;
    jump_p0     = 1'b0;
    known_p0    = 1'b1;
`ifdef CTRL_PIPE_MD_UNIT_EN
    md_p0       = 1'b0;
`endif
    case (op_p0)
      OP_RTYPE: begin
        regdst_p0 = 1'b1;
        regwr_p0  = 1'b1;
        case (fn_p0)
          6'b100000: aluc_p0 = ALU_ADD;
          6'b100010: aluc_p0 = ALU_SUB;
          6'b100100: aluc_p0 = ALU_AND;
          6'b100101: aluc_p0 = ALU_OR;
          6'b100110: aluc_p0 = ALU_XOR;
          6'b100111: aluc_p0 = ALU_NOR;
          6'b000000: aluc_p0 = ALU_SLL;
          6'b000011: aluc_p0 = ALU_SRA;
          6'b000010: aluc_p0 = ALU_SRL;
          6'b101010: aluc_p0 = ALU_SLT;
          6'b001000,
          6'b001001: jump_p0 = 1'b1;
`ifdef CTRL_PIPE_MD_UNIT_EN
          6'b011000: begin
            regwr_p0 = 1'b0;
            aluc_p0  = ALU_MUL;
            md_p0    = 1'b1;
          end
          6'b011010: begin
            regwr_p0 = 1'b0;
            aluc_p0  = ALU_DIV;
            md_p0    = 1'b1;
          end
`endif
          default:   known_p0 = 1'b0;
        endcase
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: begin
        alusrc_p0 = 1'b1;
        regwr_p0  = 1'b1;
        case (op_p0)
          OP_ANDI: aluc_p0 = ALU_AND;
          OP_ORI:  aluc_p0 = ALU_OR;
          OP_XORI: aluc_p0 = ALU_XOR;
          OP_SLTI: aluc_p0 = ALU_SLT;
          default: aluc_p0 = ALU_ADD;
        endcase
      end
      OP_LW: begin
        alusrc_p0   = 1'b1;
        regwr_p0    = 1'b1;
        memrd_p0    = 1'b1;
        memtoreg_p0 = 1'b1;
        aluc_p0     = ALU_ADD;
      end
      OP_SW: begin
        alusrc_p0 = 1'b1;
        memwr_p0  = 1'b1;
        aluc_p0   = ALU_ADD;
      end
      OP_BEQ: begin
        beq_p0  = 1'b1;
        aluc_p0 = ALU_SUB;
      end
      OP_BNE: begin
        bne_p0  = 1'b1;
        aluc_p0 = ALU_SUB;
      end
      OP_J, OP_JAL: begin
        jump_p0 = 1'b1;
        aluc_p0 = ALU_ADD;
      end
      default: known_p0 = 1'b0;
    endcase
    // Unknown encodings must reach EX as a harmless all-zero bundle.
    if (!known_p0) begin
      regwr_p0    = 1'b0;
      memtoreg_p0 = 1'b0;
      memrd_p0    = 1'b0;
      memwr_p0    = 1'b0;
      regdst_p0   = 1'b0;
      alusrc_p0   = 1'b0;
      aluc_p0     = ALU_AND;
      beq_p0      = 1'b0;
      bne_p0      = 1'b0;
      jump_p0     = 1'b0;
    end
  end

  assign rtsrc_p0 = (op_p0 == OP_RTYPE) || (op_p0 == OP_BEQ) ||
                    (op_p0 == OP_BNE) || (op_p0 == OP_SW);

  assign beq  = id_valid & beq_p0;
  assign bne  = id_valid & bne_p0;
  assign jump = id_valid & jump_p0;

  logic              vld_p1;
  logic [1:0]        wb_p1;
  logic [1:0]        m_p1;
  logic [ALUC_W+1:0] ex_p1;
  logic [4:0]        rs_p1;
  logic [4:0]        rt_p1;
  logic [4:0]        rd_p1;
  logic              illegal_p1;
  logic              md_busy_p1;
  logic              advance;
  logic              hazard;
  logic              accept;

  assign advance  = ex_ready | ~vld_p1;
  assign hazard   = vld_p1 & m_p1[1] & (rt_p1 != 5'd0) &
                    ((rt_p1 == rs_p0) | (rtsrc_p0 & (rt_p1 == rt_p0)));
  assign id_ready = advance & ~hazard & ~md_busy_p1;
  assign accept   = id_valid & id_ready & ~flush;

  // ---- EX stage (p1): ID/EX control register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      wb_p1      <= '0;
      m_p1       <= '0;
      ex_p1      <= '0;
      rs_p1      <= '0;
      rt_p1      <= '0;
      rd_p1      <= '0;
      illegal_p1 <= 1'b0;
    end else begin
      illegal_p1 <= accept & ~known_p0;
      if (advance) begin
        vld_p1 <= accept;
        if (accept) begin
          wb_p1 <= {regwr_p0, memtoreg_p0};
          m_p1  <= {memrd_p0, memwr_p0};
          ex_p1 <= {regdst_p0, alusrc_p0, aluc_p0};
          rs_p1 <= rs_p0;
          rt_p1 <= rt_p0;
          rd_p1 <= rd_p0;
        end else begin
          wb_p1 <= '0;
          m_p1  <= '0;
          ex_p1 <= '0;
          rs_p1 <= '0;
          rt_p1 <= '0;
          rd_p1 <= '0;
        end
      end
    end
  end

`ifdef CTRL_PIPE_MD_UNIT_EN
  localparam int CNT_W = (MD_CYCLES > 1) ? $clog2(MD_CYCLES) : 1;

  typedef enum logic {MD_IDLE = 1'b0, MD_BUSY = 1'b1} md_state_e;

  md_state_e        md_state_p1;
  logic [CNT_W-1:0] md_cnt_p1;

  // ---- MULT/DIV sequencer: busy for MD_CYCLES cycles after acceptance ----
  always_ff @(posedge clk) begin
    if (rst) begin
      md_state_p1 <= MD_IDLE;
      md_cnt_p1   <= '0;
      md_busy_p1  <= 1'b0;
    end else begin
      case (md_state_p1)
        MD_IDLE: begin
          if (accept & md_p0) begin
            md_state_p1 <= MD_BUSY;
            md_cnt_p1   <= CNT_W'(MD_CYCLES - 1);
            md_busy_p1  <= 1'b1;
          end
        end
        MD_BUSY: begin
          if (md_cnt_p1 == '0) begin
            md_state_p1 <= MD_IDLE;
            md_busy_p1  <= 1'b0;
          end else begin
            md_cnt_p1 <= md_cnt_p1 - CNT_W'(1);
          end
        end
        default: begin
          md_state_p1 <= MD_IDLE;
          md_busy_p1  <= 1'b0;
        end
      endcase
    end
  end
`else
  assign md_busy_p1 = 1'b0;
`endif

  assign ex_valid = vld_p1;
  assign ex_wb    = wb_p1;
  assign ex_m     = m_p1;
  assign ex_ex    = ex_p1;
  assign ex_rs    = rs_p1;
  assign ex_rt    = rt_p1;
  assign ex_rd    = rd_p1;
  assign illegal  = illegal_p1;
  assign md_busy  = md_busy_p1;

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Self-checking bench for ctrl_pipe_unit: directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_ctrl_pipe_unit;
  localparam int ALUC_W    = 4;
  localparam int MD_CYCLES = 8;
`ifdef CTRL_PIPE_MD_UNIT_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = '0;
  logic        id_valid = 1'b0;
  logic        ex_ready = 1'b1;
  logic        flush = 1'b0;
  logic        id_ready, ex_valid, beq, bne, jump, md_busy, illegal;
  logic [1:0]  ex_wb, ex_m;
  logic [ALUC_W+1:0] ex_ex;
  logic [4:0]  ex_rs, ex_rt, ex_rd;

  always #5 clk = ~clk;

  ctrl_pipe_unit #(.ALUC_W(ALUC_W), .MD_CYCLES(MD_CYCLES)) dut (
    .clk(clk), .rst(rst), .instr(instr), .id_valid(id_valid), .ex_ready(ex_ready),
    .flush(flush), .id_ready(id_ready), .ex_valid(ex_valid), .ex_wb(ex_wb), .ex_m(ex_m),
    .ex_ex(ex_ex), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .beq(beq), .bne(bne),
    .jump(jump), .md_busy(md_busy), .illegal(illegal)
  );

  int total = 0;
  int bad = 0;

  // Reference decode: what each encoding should produce, written straight from the instruction table.
  typedef struct packed {
    logic       known;
    logic [1:0] wb;
    logic [1:0] m;
    logic [5:0] ex;
    logic       b;
    logic       n;
    logic       j;
    logic       md;
  } dec_t;

  function automatic dec_t ref_dec(input logic [31:0] i);
    dec_t d;
    logic [5:0] op, fn;
    op = i[31:26];
    fn = i[5:0];
    d = '0;
    d.known = 1'b1;
    case (op)
      6'h00: begin
        d.wb = 2'b10;
        d.ex[5] = 1'b1;
        case (fn)
          6'h20: d.ex[3:0] = 4'd2;
          6'h22: d.ex[3:0] = 4'd6;
          6'h24: d.ex[3:0] = 4'd0;
          6'h25: d.ex[3:0] = 4'd1;
          6'h26: d.ex[3:0] = 4'd9;
          6'h27: d.ex[3:0] = 4'd12;
          6'h00: d.ex[3:0] = 4'd10;
          6'h03: d.ex[3:0] = 4'd11;
          6'h02: d.ex[3:0] = 4'd3;
          6'h2a: d.ex[3:0] = 4'd7;
          6'h08, 6'h09: d.j = 1'b1;
          6'h18, 6'h1a: begin
            if (MD_EN) begin
              d.wb = 2'b00;
              d.md = 1'b1;
              d.ex[3:0] = (fn == 6'h18) ? 4'd4 : 4'd5;
            end else d.known = 1'b0;
          end
          default: d.known = 1'b0;
        endcase
      end
      6'h08: begin d.wb = 2'b10; d.ex = 6'b01_0010; end
      6'h0c: begin d.wb = 2'b10; d.ex = 6'b01_0000; end
      6'h0d: begin d.wb = 2'b10; d.ex = 6'b01_0001; end
      6'h0e: begin d.wb = 2'b10; d.ex = 6'b01_1001; end
      6'h0a: begin d.wb = 2'b10; d.ex = 6'b01_0111; end
      6'h23: begin d.wb = 2'b11; d.m = 2'b10; d.ex = 6'b01_0010; end
      6'h2b: begin d.m = 2'b01; d.ex = 6'b01_0010; end
      6'h04: begin d.b = 1'b1; d.ex = 6'b00_0110; end
      6'h05: begin d.n = 1'b1; d.ex = 6'b00_0110; end
      6'h02, 6'h03: begin d.j = 1'b1; d.ex = 6'b00_0010; end
      default: d.known = 1'b0;
    endcase
    if (!d.known) d = '0;
    return d;
  endfunction

  function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] rs, rt, rd);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt);
    return {op, rs, rt, 16'h1234};
  endfunction

  // Model state: contents of the EX register and remaining busy cycles.
  logic       mv, mill;
  logic [1:0] mwb, mm;
  logic [5:0] mex;
  logic [4:0] mrs, mrt, mrd;
  int         mleft;
  dec_t       cur;
  logic       e_ready, e_acc;

  task automatic model_comb();
    logic haz, rtsrc;
    cur = ref_dec(instr);
    rtsrc = (instr[31:26] == 6'h00) || (instr[31:26] == 6'h04) ||
            (instr[31:26] == 6'h05) || (instr[31:26] == 6'h2b);
    haz = mv && mm[1] && (mrt != 0) && ((mrt == instr[25:21]) || (rtsrc && mrt == instr[20:16]));
    e_ready = (ex_ready || !mv) && !haz && (mleft == 0);
    e_acc = id_valid && e_ready && !flush;
  endtask

  task automatic model_seq();
    if (rst) begin
      mv = 0; mill = 0; mwb = 0; mm = 0; mex = 0; mrs = 0; mrt = 0; mrd = 0; mleft = 0;
    end else begin
      mill = e_acc && !cur.known;
      if (mleft > 0) mleft--;
      if (e_acc && cur.md) mleft = MD_CYCLES;
      if (ex_ready || !mv) begin
        mv = e_acc;
        if (e_acc) begin
          mwb = cur.wb; mm = cur.m; mex = cur.ex;
          mrs = instr[25:21]; mrt = instr[20:16]; mrd = instr[15:11];
        end else begin
          mwb = 0; mm = 0; mex = 0; mrs = 0; mrt = 0; mrd = 0;
        end
      end
    end
  endtask

  task automatic drive(input logic [31:0] i, input logic v, input logic r, input logic f,
                       input logic rs_in = 1'b0);
    @(negedge clk);
    instr = i; id_valid = v; ex_ready = r; flush = f; rst = rs_in;
    model_comb();
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_seq();
    #1;
  endtask

  task automatic do_reset();
    drive(32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_reset();
    drive(rtype(6'h20, 5'd1, 5'd2, 5'd3), 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL reset_ex_valid got=%b exp=0", ex_valid); end
    total++; if ({ex_wb, ex_m, ex_ex} !== 10'd0) begin bad++; $display("FAIL reset_bundles got=%h exp=0", {ex_wb, ex_m, ex_ex}); end
    total++; if ({ex_rs, ex_rt, ex_rd} !== 15'd0) begin bad++; $display("FAIL reset_regs got=%h exp=0", {ex_rs, ex_rt, ex_rd}); end
    total++; if ({md_busy, illegal} !== 2'b00) begin bad++; $display("FAIL reset_busy_illegal got=%b exp=00", {md_busy, illegal}); end
  endtask

  task automatic test_load_use();
    do_reset();
    drive(itype(6'h23, 5'd1, 5'd5), 1'b1, 1'b1, 1'b0);
    tick();
    total++; if ({ex_wb, ex_m, ex_rt} !== {2'b11, 2'b10, 5'd5}) begin bad++; $display("FAIL lw_in_ex got=%h exp=%h", {ex_wb, ex_m, ex_rt}, {2'b11, 2'b10, 5'd5}); end
    drive(rtype(6'h20, 5'd5, 5'd6, 5'd7), 1'b1, 1'b1, 1'b0);
    total++; if (id_ready !== 1'b0) begin bad++; $display("FAIL hazard_id_ready got=%b exp=0", id_ready); end
    tick();
    total++; if ({ex_valid, ex_wb, ex_m} !== 5'd0) begin bad++; $display("FAIL hazard_bubble got=%b exp=00000", {ex_valid, ex_wb, ex_m}); end
    drive(rtype(6'h20, 5'd5, 5'd6, 5'd7), 1'b1, 1'b1, 1'b0);
    total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL hazard_release got=%b exp=1", id_ready); end
    tick();
    total++; if ({ex_valid, ex_ex, ex_rd} !== {1'b1, 6'b10_0010, 5'd7}) begin bad++; $display("FAIL add_after_bubble got=%h exp=%h", {ex_valid, ex_ex, ex_rd}, {1'b1, 6'b10_0010, 5'd7}); end
  endtask

  task automatic test_zero_reg();
    do_reset();
    drive(itype(6'h23, 5'd1, 5'd0), 1'b1, 1'b1, 1'b0);
    tick();
    drive(rtype(6'h20, 5'd0, 5'd0, 5'd4), 1'b1, 1'b1, 1'b0);
    total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL zero_reg_no_stall got=%b exp=1", id_ready); end
    tick();
    total++; if ({ex_valid, ex_wb} !== 3'b110) begin bad++; $display("FAIL zero_reg_enter got=%b exp=110", {ex_valid, ex_wb}); end
  endtask

  task automatic test_md();
    int busy_cnt, acc_cycle;
    do_reset();
    drive(rtype(6'h18, 5'd1, 5'd2, 5'd0), 1'b1, 1'b1, 1'b0);
    tick();
    if (MD_EN) begin
      total++; if ({ex_wb, ex_ex[3:0], md_busy} !== {2'b00, 4'b0100, 1'b1}) begin bad++; $display("FAIL mult_ex got=%b exp=0001001", {ex_wb, ex_ex[3:0], md_busy}); end
      busy_cnt = 0; acc_cycle = 0;
      for (int c = 1; c <= 20; c++) begin
        drive(itype(6'h08, 5'd3, 5'd4), 1'b1, 1'b1, 1'b0);
        if (md_busy === 1'b1) busy_cnt++;
        if (id_ready === 1'b1) begin acc_cycle = c; tick(); break; end
        tick();
      end
      total++; if (busy_cnt !== MD_CYCLES) begin bad++; $display("FAIL mult_busy_cycles got=%0d exp=%0d", busy_cnt, MD_CYCLES); end
      total++; if (acc_cycle !== MD_CYCLES + 1) begin bad++; $display("FAIL addi_accept_cycle got=%0d exp=%0d", acc_cycle, MD_CYCLES + 1); end
      total++; if ({ex_valid, ex_ex} !== {1'b1, 6'b01_0010}) begin bad++; $display("FAIL addi_after_mult got=%b exp=1010010", {ex_valid, ex_ex}); end
      drive(rtype(6'h1a, 5'd1, 5'd2, 5'd0), 1'b1, 1'b1, 1'b0);
      tick();
      total++; if (ex_ex[3:0] !== 4'b0101) begin bad++; $display("FAIL div_code got=%b exp=0101", ex_ex[3:0]); end
      drive(32'h0, 1'b0, 1'b1, 1'b0);
      tick();
      drive(32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
      tick();
      total++; if (md_busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b exp=0", md_busy); end
    end else begin
      total++; if ({illegal, ex_wb, ex_m, md_busy} !== 6'b100000) begin bad++; $display("FAIL mult_disabled got=%b exp=100000", {illegal, ex_wb, ex_m, md_busy}); end
    end
  endtask

  task automatic test_stall();
    do_reset();
    drive(itype(6'h2b, 5'd1, 5'd2), 1'b1, 1'b1, 1'b0);
    tick();
    total++; if (ex_m !== 2'b01) begin bad++; $display("FAIL sw_in_ex got=%b exp=01", ex_m); end
    for (int k = 0; k < 2; k++) begin
      drive(rtype(6'h20, 5'd3, 5'd4, 5'd5), 1'b1, 1'b0, 1'b0);
      total++; if (id_ready !== 1'b0) begin bad++; $display("FAIL stall_id_ready got=%b exp=0", id_ready); end
      tick();
      total++; if ({ex_valid, ex_m, ex_rt} !== {1'b1, 2'b01, 5'd2}) begin bad++; $display("FAIL stall_hold got=%h exp=%h", {ex_valid, ex_m, ex_rt}, {1'b1, 2'b01, 5'd2}); end
    end
    drive(rtype(6'h20, 5'd3, 5'd4, 5'd5), 1'b1, 1'b1, 1'b0);
    total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL stall_resume got=%b exp=1", id_ready); end
    tick();
    total++; if ({ex_wb, ex_m, ex_rd} !== {2'b10, 2'b00, 5'd5}) begin bad++; $display("FAIL stall_next got=%h exp=%h", {ex_wb, ex_m, ex_rd}, {2'b10, 2'b00, 5'd5}); end
  endtask

  task automatic test_flush();
    do_reset();
    drive(itype(6'h04, 5'd1, 5'd2), 1'b1, 1'b1, 1'b1);
    total++; if ({beq, bne, jump} !== 3'b100) begin bad++; $display("FAIL beq_decode got=%b exp=100", {beq, bne, jump}); end
    tick();
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL flush_beq got=%b exp=0", ex_valid); end
    drive(rtype(6'h18, 5'd1, 5'd2, 5'd0), 1'b1, 1'b1, 1'b1);
    tick();
    drive(32'h0, 1'b0, 1'b1, 1'b0);
    total++; if ({md_busy, illegal, ex_valid} !== 3'b000) begin bad++; $display("FAIL flush_mult got=%b exp=000", {md_busy, illegal, ex_valid}); end
    tick();
    total++; if (md_busy !== 1'b0) begin bad++; $display("FAIL flush_mult_later got=%b exp=0", md_busy); end
    drive({6'h02, 26'h155}, 1'b1, 1'b1, 1'b0);
    total++; if ({beq, bne, jump} !== 3'b001) begin bad++; $display("FAIL j_decode got=%b exp=001", {beq, bne, jump}); end
    drive(itype(6'h05, 5'd1, 5'd2), 1'b0, 1'b1, 1'b0);
    total++; if (bne !== 1'b0) begin bad++; $display("FAIL bne_gated got=%b exp=0", bne); end
  endtask

  task automatic test_illegal();
    do_reset();
    drive({6'h3f, 26'h2aa_aaaa}, 1'b1, 1'b1, 1'b0);
    tick();
    total++; if ({illegal, ex_wb, ex_m} !== 5'b10000) begin bad++; $display("FAIL illegal_accept got=%b exp=10000", {illegal, ex_wb, ex_m}); end
    drive(32'h0, 1'b0, 1'b1, 1'b0);
    tick();
    total++; if (illegal !== 1'b0) begin bad++; $display("FAIL illegal_pulse got=%b exp=0", illegal); end
  endtask

  localparam logic [5:0] OP_TAB [16] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h0c, 6'h0d, 6'h0e,
                                         6'h0a, 6'h23, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h3f};
  localparam logic [5:0] FN_TAB [16] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h00, 6'h03,
                                         6'h02, 6'h2a, 6'h08, 6'h09, 6'h18, 6'h1a, 6'h3f, 6'h01};

  task automatic test_random();
    logic [31:0] i;
    logic [5:0] op;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      op = OP_TAB[$urandom_range(0, 15)];
      i = {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
           5'($urandom_range(0, 31)), FN_TAB[$urandom_range(0, 15)]};
      drive(i, ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 199) == 0));
      total++; if (id_ready !== e_ready && !rst) begin bad++; $display("FAIL rnd_id_ready c=%0d got=%b exp=%b", c, id_ready, e_ready); end
      total++; if ({beq, bne, jump} !== ({cur.b, cur.n, cur.j} & {3{id_valid}})) begin bad++; $display("FAIL rnd_branch c=%0d got=%b exp=%b", c, {beq, bne, jump}, {cur.b, cur.n, cur.j} & {3{id_valid}}); end
      tick();
      total++; if ({ex_valid, ex_wb, ex_m, ex_ex} !== {mv, mwb, mm, mex}) begin bad++; $display("FAIL rnd_ex c=%0d got=%h exp=%h", c, {ex_valid, ex_wb, ex_m, ex_ex}, {mv, mwb, mm, mex}); end
      total++; if ({ex_rs, ex_rt, ex_rd} !== {mrs, mrt, mrd}) begin bad++; $display("FAIL rnd_regs c=%0d got=%h exp=%h", c, {ex_rs, ex_rt, ex_rd}, {mrs, mrt, mrd}); end
      total++; if ({md_busy, illegal} !== {(mleft > 0), mill}) begin bad++; $display("FAIL rnd_busy_ill c=%0d got=%b exp=%b", c, {md_busy, illegal}, {(mleft > 0), mill}); end
    end
  endtask

  initial begin
    mv = 0; mill = 0; mwb = 0; mm = 0; mex = 0; mrs = 0; mrt = 0; mrd = 0; mleft = 0;
    cur = '0; e_ready = 0; e_acc = 0;
    test_reset();
    test_load_use();
    test_zero_reg();
    test_md();
    test_stall();
    test_flush();
    test_illegal();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
